// File: rtl/multi_counter_dump.sv
// multi_counter_dump
// Sole master of the SRAM multi-counter command port. Upstream event
// commands pass straight through while idle. On dump_start every id is
// READ in order, optionally followed by a CLEAR. The {id, count} responses
// are streamed out through a small FIFO with a valid/ready handshake.
module multi_counter_dump #(
    parameter int NUM_IDS    = 256,
    parameter int ID_W       = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt_valid,
    output logic              evt_ready,
    input  logic [ID_W-1:0]   evt_id,
    input  logic [2:0]        evt_cmd,
    input  logic [DATA_W-1:0] evt_data,
    input  logic              dump_start,
    input  logic              dump_clear,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cnt_valid,
    output logic [ID_W-1:0]   cnt_id,
    output logic [2:0]        cnt_cmd,
    output logic [DATA_W-1:0] cnt_data,
    input  logic              cnt_rvalid,
    input  logic [DATA_W-1:0] cnt_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ID_W-1:0]   dump_id,
    output logic [DATA_W-1:0] dump_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] CMD_LOAD  = 3'b000;
    localparam logic [2:0] CMD_CLEAR = 3'b001;
    localparam logic [2:0] CMD_READ  = 3'b100;

    // The sweep index is one bit wider than an id so a full 2**ID_W sweep
    // can step past the last id without wrapping back to zero.
    localparam logic [ID_W:0]  LAST_IDX = (ID_W + 1)'(NUM_IDS - 1);
    localparam logic [ID_W:0]  IDX_ONE  = (ID_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CLR,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ID_W:0]      idx;
    logic               clear_mode;
    logic               outstanding;
    logic [ID_W-1:0]    rsp_id;
    logic               last_rsp;

    logic [ID_W-1:0]    fifo_id   [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic               evt_accept;
    logic               space_ok;
    logic               read_issue;
    logic               clear_issue;
    logic               idx_last;
    logic               push;
    logic               pop;
    logic [CNT_W:0]     occupancy;

    // Idle gives the sweep request priority over an upstream event.
    assign evt_accept  = (state == S_IDLE) && evt_valid && !dump_start && !rst;

    // A READ is only issued when its response is guaranteed a FIFO slot,
    // counting the one that may still be in flight.
    assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding};
    assign space_ok    = occupancy < DEPTH;
    assign read_issue  = (state == S_RD) && space_ok && !rst;
    assign clear_issue = (state == S_CLR) && !rst;
    assign idx_last    = (idx == LAST_IDX);

    assign push        = cnt_rvalid && outstanding;
    assign pop         = dump_valid && dump_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection for the sweep sequencer.
    always_comb begin
        // NOTE: default first so no path through the case leaves the
        // variable unassigned, which would infer a latch.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dump_start) begin
                    state_next = S_RD;
                end
            end
            S_RD: begin
                if (read_issue) begin
                    if (clear_mode) begin
                        state_next = S_CLR;
                    end else if (idx_last) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_CLR: begin
                state_next = idx_last ? S_DRAIN : S_RD;
            end
            S_DRAIN: begin
                if (!outstanding || push) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command port mux and status outputs.
    always_comb begin
        cnt_valid = 1'b0;
        cnt_id    = idx[ID_W-1:0];
        cnt_cmd   = CMD_READ;
        cnt_data  = '0;
        evt_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                evt_ready = !dump_start && !rst;
                cnt_valid = evt_accept && !evt_cmd[2];
                cnt_id    = evt_id;
                cnt_cmd   = evt_cmd;
                cnt_data  = evt_data;
            end
            S_RD: begin
                busy      = 1'b1;
                cnt_valid = read_issue;
            end
            S_CLR: begin
                busy      = 1'b1;
                cnt_valid = clear_issue;
                cnt_cmd   = CMD_CLEAR;
            end
            S_DRAIN: begin
                busy      = 1'b1;
            end
            default: begin
                cnt_cmd   = CMD_LOAD;
            end
        endcase
        err  = !rst && ((evt_accept && evt_cmd[2]) || (cnt_rvalid && !outstanding));
        done = !rst && push && last_rsp;
    end

    // Sweep index, clear-mode latch and in-flight READ tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            clear_mode  <= 1'b0;
            outstanding <= 1'b0;
            rsp_id      <= '0;
            last_rsp    <= 1'b0;
        end else begin
            if (state == S_IDLE && dump_start) begin
                idx        <= '0;
                clear_mode <= dump_clear;
            end
            if (read_issue) begin
                outstanding <= 1'b1;
                rsp_id      <= idx[ID_W-1:0];
                last_rsp    <= idx_last;
                if (!clear_mode) begin
                    idx <= idx + IDX_ONE;
                end
            end else if (push) begin
                outstanding <= 1'b0;
                last_rsp    <= 1'b0;
            end
            if (clear_issue) begin
                idx <= idx + IDX_ONE;
            end
        end
    end

    // FIFO storage: written on push only.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the reset pointers and count
        // already mark every entry invalid, so clearing it buys nothing.
        if (push) begin
            fifo_id[wr_ptr]   <= rsp_id;
            fifo_data[wr_ptr] <= cnt_rdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign dump_valid = (fifo_count != '0);
    assign dump_id    = fifo_id[rd_ptr];
    assign dump_data  = fifo_data[rd_ptr];

endmodule

// File: tb/tb_multi_counter_dump.sv
// tb_multi_counter_dump
// Directed bench for multi_counter_dump with a behavioural SRAM counter
// model (1-cycle READ latency) attached to the command port.
module tb_multi_counter_dump;

    localparam int NUM_IDS    = 256;
    localparam int ID_W       = 8;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              evt_valid;
    logic              evt_ready;
    logic [ID_W-1:0]   evt_id;
    logic [2:0]        evt_cmd;
    logic [DATA_W-1:0] evt_data;
    logic              dump_start;
    logic              dump_clear;
    logic              busy;
    logic              done;
    logic              err;
    logic              cnt_valid;
    logic [ID_W-1:0]   cnt_id;
    logic [2:0]        cnt_cmd;
    logic [DATA_W-1:0] cnt_data;
    logic              cnt_rvalid;
    logic [DATA_W-1:0] cnt_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [ID_W-1:0]   dump_id;
    logic [DATA_W-1:0] dump_data;

    // Counter model
    logic [DATA_W-1:0] mem [NUM_IDS];
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              inject_rvalid;
    logic              model_clr;

    // Expected counter contents, maintained by hand in the stimulus
    logic [DATA_W-1:0] exp_val [NUM_IDS];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_id;
    int done_cnt;
    int cycles;
    int evt_leak;
    int reads;
    int stall_viol;

    multi_counter_dump #(
        .NUM_IDS(NUM_IDS), .ID_W(ID_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_cmd(evt_cmd), .evt_data(evt_data),
        .dump_start(dump_start), .dump_clear(dump_clear),
        .busy(busy), .done(done), .err(err),
        .cnt_valid(cnt_valid), .cnt_id(cnt_id), .cnt_cmd(cnt_cmd), .cnt_data(cnt_data),
        .cnt_rvalid(cnt_rvalid), .cnt_rdata(cnt_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_id(dump_id), .dump_data(dump_data)
    );

    always #5 clk = ~clk;

    assign cnt_rvalid = rsp_valid | inject_rvalid;
    assign cnt_rdata  = rsp_data;

    // SRAM counter: commands take effect at the edge, READ answers one cycle later
    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < NUM_IDS; i++) mem[i] <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (cnt_valid) begin
                case (cnt_cmd)
                    3'b000: mem[cnt_id] <= cnt_data;
                    3'b001: mem[cnt_id] <= '0;
                    3'b010: mem[cnt_id] <= mem[cnt_id] + 8'd1;
                    3'b011: mem[cnt_id] <= mem[cnt_id] - 8'd1;
                    3'b100: begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem[cnt_id];
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse dump_start for one idle cycle; the sweep is running on return.
    task automatic start_sweep(input logic clr);
        exp_id     = 0;
        done_cnt   = 0;
        evt_leak   = 0;
        dump_start = 1'b1;
        dump_clear = clr;
        @(negedge clk);
        check("start_evt_ready", 32'(evt_ready), 32'd0);
        check("start_cnt_valid", 32'(cnt_valid), 32'd0);
        next_cycle();
        dump_start = 1'b0;
        dump_clear = 1'b0;
    endtask

    // Pop entries until the sweep is finished and the FIFO is empty.
    task automatic collect(input int budget);
        logic finished;
        finished = 1'b0;
        cycles   = 0;
        while (!finished && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done) done_cnt++;
            if (busy && evt_ready) evt_leak++;
            if (dump_valid && dump_ready) begin
                check("dump_id", 32'(dump_id), 32'(exp_id));
                if (exp_id < NUM_IDS)
                    check("dump_data", 32'(dump_data), 32'(exp_val[exp_id[ID_W-1:0]]));
                exp_id++;
            end
            finished = !busy && !dump_valid;
            next_cycle();
        end
        check("collect_finished", 32'(finished), 32'd1);
        check("collect_entries", 32'(exp_id), 32'(NUM_IDS));
        check("collect_done_once", 32'(done_cnt), 32'd1);
        check("collect_no_evt_ready_busy", 32'(evt_leak), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        model_clr     = 1'b1;
        evt_valid     = 1'b0;
        evt_id        = '0;
        evt_cmd       = 3'b000;
        evt_data      = '0;
        dump_start    = 1'b0;
        dump_clear    = 1'b0;
        dump_ready    = 1'b0;
        inject_rvalid = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) exp_val[i] = '0;

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt_valid", 32'(cnt_valid), 32'd0);
        check("rst_evt_ready", 32'(evt_ready), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        next_cycle();
        rst       = 1'b0;
        model_clr = 1'b0;
        @(negedge clk);
        check("idle_evt_ready", 32'(evt_ready), 32'd1);
        next_cycle();

        // INC id 5 three times back to back
        evt_valid = 1'b1;
        evt_id    = 8'd5;
        evt_cmd   = 3'b010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("inc_cnt_valid", 32'(cnt_valid), 32'd1);
            check("inc_cnt_cmd", 32'(cnt_cmd), 32'h2);
            check("inc_cnt_id", 32'(cnt_id), 32'd5);
            check("inc_err", 32'(err), 32'd0);
            check("inc_busy", 32'(busy), 32'd0);
            next_cycle();
        end
        exp_val[5] = 8'd3;

        // LOAD id 2 = 0x7F
        evt_id   = 8'd2;
        evt_cmd  = 3'b000;
        evt_data = 8'h7F;
        @(negedge clk);
        check("load_cnt_cmd", 32'(cnt_cmd), 32'h0);
        check("load_cnt_data", 32'(cnt_data), 32'h7F);
        next_cycle();
        evt_valid = 1'b0;
        exp_val[2] = 8'h7F;

        // Read-only sweep with consumer always ready: 1 id per cycle
        dump_ready = 1'b1;
        start_sweep(1'b0);
        collect(600);
        check("ro_cycles", 32'(cycles <= 262), 32'd1);

        // Same sweep with consumer stalled: exactly FIFO_DEPTH entries buffered
        dump_ready = 1'b0;
        start_sweep(1'b0);
        reads      = 0;
        stall_viol = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cnt_valid && cnt_cmd == 3'b100) reads++;
            if (k >= 6 && cnt_valid) stall_viol++;
            next_cycle();
        end
        check("stall_reads", 32'(reads), 32'(FIFO_DEPTH));
        check("stall_cnt_valid", 32'(stall_viol), 32'd0);
        @(negedge clk);
        check("stall_dump_valid", 32'(dump_valid), 32'd1);
        check("stall_head_id", 32'(dump_id), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        next_cycle();
        dump_ready = 1'b1;
        collect(600);

        // Clear mode: READ id 0 then CLEAR id 0 on the next cycle
        evt_valid = 1'b1;
        evt_id    = 8'd0;
        evt_cmd   = 3'b000;
        evt_data  = 8'd9;
        next_cycle();
        evt_valid = 1'b0;
        exp_val[0] = 8'd9;
        start_sweep(1'b1);
        @(negedge clk);
        check("clr_rd_valid", 32'(cnt_valid), 32'd1);
        check("clr_rd_cmd", 32'(cnt_cmd), 32'h4);
        check("clr_rd_id", 32'(cnt_id), 32'd0);
        next_cycle();
        @(negedge clk);
        check("clr_clr_valid", 32'(cnt_valid), 32'd1);
        check("clr_clr_cmd", 32'(cnt_cmd), 32'h1);
        check("clr_clr_id", 32'(cnt_id), 32'd0);
        next_cycle();
        collect(700);
        check("clr_cycles", 32'(cycles <= 520), 32'd1);
        for (int i = 0; i < NUM_IDS; i++) exp_val[i] = '0;

        // Second sweep after clear: everything reads back zero
        start_sweep(1'b0);
        collect(600);

        // dump_start wins over a simultaneous LOAD; LOAD goes through after
        evt_valid = 1'b1;
        evt_id    = 8'd7;
        evt_cmd   = 3'b000;
        evt_data  = 8'h33;
        start_sweep(1'b0);
        collect(600);
        @(negedge clk);
        check("post_evt_ready", 32'(evt_ready), 32'd1);
        check("post_cnt_valid", 32'(cnt_valid), 32'd1);
        check("post_cnt_cmd", 32'(cnt_cmd), 32'h0);
        check("post_cnt_id", 32'(cnt_id), 32'd7);
        check("post_cnt_data", 32'(cnt_data), 32'h33);
        next_cycle();
        evt_valid = 1'b0;
        exp_val[7] = 8'h33;

        // Upstream READ is rejected with an err pulse
        evt_valid = 1'b1;
        evt_id    = 8'd3;
        evt_cmd   = 3'b100;
        @(negedge clk);
        check("rd_evt_err", 32'(err), 32'd1);
        check("rd_evt_cnt_valid", 32'(cnt_valid), 32'd0);
        check("rd_evt_ready", 32'(evt_ready), 32'd1);
        next_cycle();
        evt_valid = 1'b0;
        @(negedge clk);
        check("rd_evt_err_clears", 32'(err), 32'd0);
        next_cycle();

        // Stray response with nothing outstanding
        inject_rvalid = 1'b1;
        @(negedge clk);
        check("stray_err", 32'(err), 32'd1);
        next_cycle();
        inject_rvalid = 1'b0;
        @(negedge clk);
        check("stray_dropped", 32'(dump_valid), 32'd0);
        check("stray_err_clears", 32'(err), 32'd0);
        next_cycle();

        // Reset in the middle of a sweep
        start_sweep(1'b0);
        for (int k = 0; k < 10; k++) next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_cnt_valid", 32'(cnt_valid), 32'd0);
        check("mid_rst_evt_ready", 32'(evt_ready), 32'd0);
        check("mid_rst_dump_valid", 32'(dump_valid), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Sweep after reset restarts at id 0 with the SRAM untouched
        start_sweep(1'b0);
        collect(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
